// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches words over a req/ack memory handshake and
// hands each instruction to decode through a single-entry valid/ready register.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [1:0] {
    S_REQ       = 2'd0,
    S_WAIT_DROP = 2'd1,
    S_HOLD      = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  assign opcode = instr[INSTR_W-1 -: OP_W];

  // imem_addr is only reloaded when a new request starts, keeping it stable
  // for the whole life of an outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      ir_valid  <= 1'b0;
      instr     <= '0;
      instr_pc  <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            // First cycle out of reset: nothing outstanding yet.
            imem_req <= 1'b1;
            if (redirect) begin
              pc        <= redirect_pc;
              imem_addr <= redirect_pc;
            end else begin
              imem_addr <= pc;
            end
          end else if (redirect) begin
            pc <= redirect_pc;
            if (imem_ack) imem_addr <= redirect_pc;
            else          state     <= S_WAIT_DROP;
          end else if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            pc       <= pc + ADDR_W'(1);
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            state    <= S_HOLD;
          end
        end

        S_WAIT_DROP: begin
          if (redirect) pc <= redirect_pc;
          if (imem_ack) begin
            state     <= S_REQ;
            imem_addr <= redirect ? redirect_pc : pc;
          end
        end

        S_HOLD: begin
          // A redirect wins over ir_ready; either way the IR is released.
          if (redirect || ir_ready) begin
            ir_valid  <= 1'b0;
            imem_req  <= 1'b1;
            state     <= S_REQ;
            imem_addr <= redirect ? redirect_pc : pc;
            if (redirect) pc <= redirect_pc;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule
